// File: rtl/mc_muldiv_unit.sv
// mc_muldiv_unit: iterative radix-2 multiply/divide co-unit with start/busy/done handshake
// Ports: clk, reset_n (async, active-low); start/op/opa/opb request an operation,
// abort cancels one in flight; busy covers PREP..FIX, done pulses with new
// result_lo/result_hi/div_by_zero, which are held registers.
module mc_muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t state_q, state_d;
   logic [1:0] op_r;
   logic [WIDTH-1:0] a_r, b_r, m_r, a_abs, b_abs, quo, rmd;
   logic [WIDTH:0] rem;
   logic [2*WIDTH-1:0] acc, prod;
   logic [CW-1:0] cnt;
   logic neg_res, neg_rem, accept, is_div, div_zero, last;
   logic [WIDTH:0] mul_sum;
   logic [WIDTH+1:0] div_sh, div_t;
   assign is_div   = op_r[1];
   assign accept   = start && !abort && (state_q == IDLE || state_q == DONE);
   assign div_zero = is_div && b_r == '0;
   assign last     = cnt == CW'(WIDTH - 1);
   assign a_abs    = (op_r[0] && a_r[WIDTH-1]) ? -a_r : a_r;
   assign b_abs    = (op_r[0] && b_r[WIDTH-1]) ? -b_r : b_r;
   // Multiply: acc = {partial product, remaining multiplier bits}, m_r = multiplicand.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_r} : '0);
   // Divide: acc low half shifts dividend bits out MSB first and quotient bits in; m_r = divisor.
   assign div_sh   = {rem, acc[WIDTH-1]};
   assign div_t    = div_sh - {2'b0, m_r};
   assign prod     = neg_res ? -acc : acc;
   assign quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rmd      = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: state_d = accept ? PREP : IDLE;
         PREP: begin
            busy    = 1'b1;
            state_d = abort ? IDLE : div_zero ? DONE : ITER;
         end
         ITER: begin
            busy    = 1'b1;
            state_d = abort ? IDLE : last ? FIX : ITER;
         end
         FIX: begin
            busy    = 1'b1;
            state_d = abort ? IDLE : DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = accept ? PREP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         m_r         <= '0;
         rem         <= '0;
         acc         <= '0;
         cnt         <= '0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            op_r <= op;
            a_r  <= opa;
            b_r  <= opb;
         end
         if (!abort)
            case (state_q)
               PREP: begin
                  neg_res <= op_r[0] && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                  neg_rem <= op_r[0] && a_r[WIDTH-1];
                  m_r     <= is_div ? b_abs : a_abs;
                  acc     <= {{WIDTH{1'b0}}, is_div ? a_abs : b_abs};
                  rem     <= '0;
                  cnt     <= '0;
                  if (div_zero) begin
                     result_lo   <= '1;
                     result_hi   <= a_r;
                     div_by_zero <= 1'b1;
                  end
               end
               ITER: begin
                  cnt <= cnt + 1'b1;
                  if (is_div) begin
                     rem            <= div_t[WIDTH+1] ? div_sh[WIDTH:0] : div_t[WIDTH:0];
                     acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_t[WIDTH+1]};
                  end else
                     acc <= {mul_sum, acc[WIDTH-1:1]};
               end
               FIX: begin
                  result_lo   <= is_div ? quo : prod[WIDTH-1:0];
                  result_hi   <= is_div ? rmd : prod[2*WIDTH-1:WIDTH];
                  div_by_zero <= 1'b0;
               end
               default: ;
            endcase
      end
endmodule
